// File: rtl/brush_rect_queue.sv
// brush_rect_queue: clamps pen points into brush rectangles, queues them in a FIFO and
// offers them one at a time to the display controller with a post-accept holdoff.
module brush_rect_queue #(
    parameter int NUM_COLS    = 240,
    parameter int NUM_ROWS    = 320,
    parameter int COLOR_WIDTH = 3,
    parameter int DEPTH       = 8,
    parameter int HOLDOFF     = 64,
    localparam int CW = $clog2(NUM_COLS),
    localparam int RW = $clog2(NUM_ROWS),
    localparam int PW = $clog2(DEPTH),
    localparam int NW = PW + 1,
    localparam int TW = $clog2(HOLDOFF + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   point_valid_in,
    input  logic [CW-1:0]          point_col_in,
    input  logic [RW-1:0]          point_row_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic [3:0]             radius_in,
    input  logic                   clear_in,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic [CW-1:0]          col1_out,
    output logic [CW-1:0]          col2_out,
    output logic [RW-1:0]          row1_out,
    output logic [RW-1:0]          row2_out,
    output logic [COLOR_WIDTH-1:0] color_out,
    output logic [NW-1:0]          count_out,
    output logic                   overflow_out
);
    localparam int RECT_W = 2 * CW + 2 * RW + COLOR_WIDTH;
    localparam int PT_W   = CW + RW + COLOR_WIDTH + 4;

    typedef enum logic [1:0] {IDLE, OFFER, WAIT} state_t;

    logic [CW:0]             col_w, col_r, col_sum;
    logic [RW:0]             row_w, row_r, row_sum;
    logic [CW-1:0]           col_lo, col_hi;
    logic [RW-1:0]           row_lo, row_hi;
    logic [PT_W-1:0]         pt, last_q;
    logic [RECT_W-1:0]       rect_d, s1_rect_q, out_q;
    logic [RECT_W-1:0]       mem_q [DEPTH];
    logic                    in_range, dup, accept, full, pop, push;
    logic                    s1_valid_q, last_valid_q, overflow_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]           count_q;
    logic [TW-1:0]           timer_q;
    state_t                  state_q;

    // Clamp arithmetic runs one bit wider than the coordinate so col+r never wraps.
    always_comb begin
        col_w    = {1'b0, point_col_in};
        row_w    = {1'b0, point_row_in};
        col_r    = (CW+1)'(radius_in);
        row_r    = (RW+1)'(radius_in);
        col_sum  = col_w + col_r;
        row_sum  = row_w + row_r;
        col_lo   = col_w < col_r ? '0 : CW'(col_w - col_r);
        row_lo   = row_w < row_r ? '0 : RW'(row_w - row_r);
        col_hi   = col_sum > (CW+1)'(NUM_COLS - 1) ? CW'(NUM_COLS - 1) : col_sum[CW-1:0];
        row_hi   = row_sum > (RW+1)'(NUM_ROWS - 1) ? RW'(NUM_ROWS - 1) : row_sum[RW-1:0];
        rect_d   = {col_lo, col_hi, row_lo, row_hi, color_in};
        pt       = {point_col_in, point_row_in, color_in, radius_in};
        in_range = col_w < (CW+1)'(NUM_COLS) && row_w < (RW+1)'(NUM_ROWS);
        dup      = last_valid_q && pt == last_q;
        accept   = point_valid_in && in_range && !dup;
        full     = count_q == NW'(DEPTH);
        pop      = state_q == OFFER && ready_in;
        push     = s1_valid_q && (!full || pop);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid_q   <= 1'b0;
            s1_rect_q    <= '0;
            last_valid_q <= 1'b0;
            last_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_rect_q    <= rect_d;
                last_valid_q <= 1'b1;
                last_q       <= pt;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_q + NW'(push) - NW'(pop);
            overflow_q <= (s1_valid_q && !push) || (overflow_q && !clear_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= s1_rect_q;
    end

    // The head is latched on entry to OFFER so the buses stay stable while waiting.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            timer_q <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (count_q != '0) begin
                    state_q <= OFFER;
                    out_q   <= mem_q[rd_ptr_q];
                end
                OFFER: if (ready_in) begin
                    state_q <= WAIT;
                    timer_q <= TW'(HOLDOFF);
                end
                WAIT: begin
                    timer_q <= timer_q - TW'(1);
                    if (!ready_in || timer_q <= TW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_out    = state_q == OFFER;
    assign {col1_out, col2_out, row1_out, row2_out, color_out} = out_q;
    assign count_out    = count_q;
    assign overflow_out = overflow_q;
endmodule

// File: tb/tb_brush_rect_queue.sv
// tb_brush_rect_queue: directed stimulus with a scoreboard queue; a negedge monitor
// checks every accepted request against hand-computed rectangles.
module tb_brush_rect_queue;
    localparam int CW = 8;
    localparam int RW = 9;
    localparam int HOLDOFF = 64;

    logic           clk = 1'b0;
    logic           rst_in = 1'b0;
    logic           point_valid_in = 1'b0;
    logic [CW-1:0]  point_col_in = '0;
    logic [RW-1:0]  point_row_in = '0;
    logic [2:0]     color_in = '0;
    logic [3:0]     radius_in = '0;
    logic           clear_in = 1'b0;
    logic           ready_in = 1'b1;
    logic           valid_out;
    logic [CW-1:0]  col1_out, col2_out;
    logic [RW-1:0]  row1_out, row2_out;
    logic [2:0]     color_out;
    logic [3:0]     count_out;
    logic           overflow_out;

    brush_rect_queue dut (
        .clk_in(clk), .rst_in(rst_in), .point_valid_in(point_valid_in),
        .point_col_in(point_col_in), .point_row_in(point_row_in), .color_in(color_in),
        .radius_in(radius_in), .clear_in(clear_in), .ready_in(ready_in),
        .valid_out(valid_out), .col1_out(col1_out), .col2_out(col2_out),
        .row1_out(row1_out), .row2_out(row2_out), .color_out(color_out),
        .count_out(count_out), .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct { int c1; int c2; int r1; int r2; int clr; } exp_t;
    exp_t exp_q[$];
    int   hs_cyc[$];
    int   total = 0, bad = 0, cyc = 0, hs_cnt = 0, hs0 = 0, s = 0;
    bit   hs_prev = 1'b0;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_in) begin
            if (hs_prev) chk("valid_drop_after_hs", int'(valid_out), 0);
            hs_prev = 1'b0;
            if (valid_out && ready_in) begin
                hs_prev = 1'b1;
                hs_cnt++;
                hs_cyc.push_back(cyc);
                chk("request_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("col1", int'(col1_out), e.c1);
                    chk("col2", int'(col2_out), e.c2);
                    chk("row1", int'(row1_out), e.r1);
                    chk("row2", int'(row2_out), e.r2);
                    chk("color", int'(color_out), e.clr);
                end
            end
        end else hs_prev = 1'b0;
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(int c, int r, int clr, int rad);
        point_col_in   = CW'(c);
        point_row_in   = RW'(r);
        color_in       = 3'(clr);
        radius_in      = 4'(rad);
        point_valid_in = 1'b1;
        @(posedge clk);
        #1;
        point_valid_in = 1'b0;
    endtask

    task automatic expect_rect(int c1, int c2, int r1, int r2, int clr);
        exp_q.push_back('{c1, c2, r1, r2, clr});
    endtask

    task automatic drain(int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_count", int'(count_out), 0);
        chk("rst_overflow", int'(overflow_out), 0);
        chk("rst_col1", int'(col1_out), 0);
        chk("rst_col2", int'(col2_out), 0);
        chk("rst_row1", int'(row1_out), 0);
        chk("rst_row2", int'(row2_out), 0);
        chk("rst_color", int'(color_out), 0);
        rst_in = 1'b1;
        idle(2);

        // lower clamp and strobe-to-valid latency
        hs_cyc.delete();
        expect_rect(0, 12, 3, 17, 3);
        s = cyc;
        strobe(5, 10, 3, 7);
        drain(20);
        chk("latency", hs_cyc.size() > 0 ? hs_cyc[0] - s : -1, 3);
        idle(70);

        // upper clamp, then out-of-range rejects
        expect_rect(234, 239, 315, 319, 5);
        strobe(238, 319, 5, 4);
        drain(20);
        idle(70);
        hs0 = hs_cnt;
        strobe(240, 0, 2, 1);
        strobe(0, 320, 2, 1);
        idle(6);
        chk("reject_count", int'(count_out), 0);
        chk("reject_no_request", hs_cnt - hs0, 0);

        // burst into a stalled display: 8 kept, 2 dropped
        ready_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expect_rect(18 + i, 22 + i, 28 + i, 32 + i, i % 8);
            strobe(20 + i, 30 + i, i % 8, 2);
        end
        idle(3);
        chk("burst_count", int'(count_out), 8);
        chk("burst_overflow", int'(overflow_out), 1);
        clear_in = 1'b1;
        idle(1);
        clear_in = 1'b0;
        chk("overflow_cleared", int'(overflow_out), 0);
        hs0 = hs_cnt;
        ready_in = 1'b1;
        drain(1000);
        chk("burst_requests", hs_cnt - hs0, 8);
        idle(70);

        // duplicate suppression
        hs0 = hs_cnt;
        expect_rect(97, 103, 97, 103, 1);
        expect_rect(97, 103, 97, 103, 2);
        strobe(100, 100, 1, 3);
        strobe(100, 100, 1, 3);
        strobe(100, 100, 2, 3);
        drain(400);
        idle(10);
        chk("dup_requests", hs_cnt - hs0, 2);
        idle(70);

        // ready held high: WAIT runs to its timeout between requests
        hs_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            expect_rect(10 + i, 10 + i, 10, 10, 1);
            strobe(10 + i, 10, 1, 0);
        end
        drain(400);
        chk("timeout_hs", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("timeout_gap1", hs_cyc[1] - hs_cyc[0], HOLDOFF + 2);
            chk("timeout_gap2", hs_cyc[2] - hs_cyc[1], HOLDOFF + 2);
        end
        idle(70);

        // display that drops ready right after accepting: minimum spacing
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_rect(29 + i, 31 + i, 39, 41, 6);
            strobe(30 + i, 40, 6, 1);
        end
        idle(5);
        hs_cyc.delete();
        repeat (30) begin
            ready_in = valid_out;
            @(posedge clk);
            #1;
        end
        ready_in = 1'b0;
        chk("fast_hs", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("fast_gap1", hs_cyc[1] - hs_cyc[0], 3);
            chk("fast_gap2", hs_cyc[2] - hs_cyc[1], 3);
        end
        chk("fast_drained", exp_q.size(), 0);
        idle(3);

        // reset while a request is offered
        for (int i = 0; i < 4; i++) strobe(50 + i, 60 + i, 4, 0);
        idle(6);
        chk("pre_reset_valid", int'(valid_out), 1);
        chk("pre_reset_count", int'(count_out), 4);
        #2 rst_in = 1'b0;
        #1;
        chk("async_rst_valid", int'(valid_out), 0);
        chk("async_rst_count", int'(count_out), 0);
        chk("async_rst_col1", int'(col1_out), 0);
        exp_q.delete();
        idle(2);
        rst_in = 1'b1;
        hs0 = hs_cnt;
        ready_in = 1'b1;
        idle(20);
        chk("post_reset_count", int'(count_out), 0);
        chk("post_reset_no_stale", hs_cnt - hs0, 0);
        expect_rect(53, 53, 63, 63, 4);
        strobe(53, 63, 4, 0);
        drain(20);
        chk("post_reset_last_cleared", hs_cnt - hs0, 1);

        idle(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
